// File: rtl/instr_mem_loader.sv
// Streams a byte image into instruction memory, zero-pads to a word boundary; writes appear 1 cycle after accept, in_ready stalls outside LOAD.
// Optional LOADER_CHECKSUM_EN adds an 8-bit XOR checksum output over every byte written, pads included.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [7:0]            wd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]            checksum,
`endif
  output logic [ADDR_WIDTH-1:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_BYTES - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic [ADDR_WIDTH-1:0] waddr_nxt;
  logic [7:0]            wd_nxt;
  logic                  we_nxt;
  logic                  word_end;
  logic                  restart;

  // The byte being written at ptr closes its 32-bit word.
  assign word_end = (ptr[1:0] == 2'b11);

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_PAD);
  assign done     = (state == S_DONE);
  assign overflow = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = byte_count;
    waddr_nxt = waddr;
    wd_nxt    = wd;
    we_nxt    = 1'b0;
    restart   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          restart   = 1'b1;
          state_nxt = S_LOAD;
          ptr_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          we_nxt    = 1'b1;
          waddr_nxt = ptr;
          wd_nxt    = in_data;
          ptr_nxt   = ptr + 1'b1;
          cnt_nxt   = byte_count + 1'b1;
          if (in_last) begin
            state_nxt = word_end ? S_DONE : S_PAD;
          end else if (ptr == LAST_ADDR) begin
            state_nxt = S_ERROR;
          end
        end
      end
      S_PAD: begin
        we_nxt    = 1'b1;
        waddr_nxt = ptr;
        wd_nxt    = 8'h00;
        ptr_nxt   = ptr + 1'b1;
        cnt_nxt   = byte_count + 1'b1;
        if (word_end) begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      byte_count <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wd         <= 8'h00;
    end else begin
      ptr        <= ptr_nxt;
      byte_count <= cnt_nxt;
      we         <= we_nxt;
      waddr      <= waddr_nxt;
      wd         <= wd_nxt;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum, csum_nxt;

  always_comb begin
    csum_nxt = csum;
    if (restart) begin
      csum_nxt = 8'h00;
    end else if (we_nxt) begin
      csum_nxt = csum ^ wd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum <= 8'h00;
    end else begin
      csum <= csum_nxt;
    end
  end

  assign checksum = csum;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes are queued as bytes are driven and checked as WE appears.
module tb_instr_mem_loader;

  localparam int AW  = 32;
  localparam int MEM = 256;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wd;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW-1:0] byte_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  instr_mem_loader #(.ADDR_WIDTH(AW), .MEM_BYTES(MEM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .we         (we),
    .waddr      (waddr),
    .wd         (wd),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
`ifdef LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every WE pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", waddr, e.addr);
        chk("wd", 32'(wd), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    in_valid = 1'b0;
    step();
    start    = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic acc, input logic [AW-1:0] a);
    wr_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    if (acc) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_pad(input logic [AW-1:0] a);
    wr_t e;
    e.addr = a;
    e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] img1 [4];
    img1[0] = 8'h03; img1[1] = 8'h10; img1[2] = 8'hA0; img1[3] = 8'hE3;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wd", 32'(wd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_byte_count", byte_count, 0);
    rst_n = 1'b1;
    idle(2);
    chk("idle_no_ready", 32'(in_ready), 0);

    // Aligned 4-byte image, no padding.
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) send(img1[i], i == 3, 1'b1, AW'(i));
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_ready_low", 32'(in_ready), 0);
    chk("t1_count", byte_count, 4);
    idle(3);
    chk("t1_drain", exp_q.size(), 0);
    chk("t1_done_hold", 32'(done), 1);

    // 6-byte image padded to 8; restart from DONE clears status.
    pulse_start();
    chk("t2_done_clr", 32'(done), 0);
    chk("t2_count_clr", byte_count, 0);
    for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), i == 5, 1'b1, AW'(i));
    expect_pad(6);
    expect_pad(7);
    chk("t2_pad_busy", 32'(busy), 1);
    chk("t2_pad_no_ready", 32'(in_ready), 0);
    chk("t2_pad_not_done", 32'(done), 0);
    idle(2);
    chk("t2_done", 32'(done), 1);
    chk("t2_count", byte_count, 8);
    idle(2);
    chk("t2_drain", exp_q.size(), 0);

    // Stall: valid 1,0,0,1 gives contiguous addresses 0,1 then pads 2,3.
    pulse_start();
    send(8'hA5, 1'b0, 1'b1, 0);
    idle(2);
    chk("t3_stall_count", byte_count, 1);
    send(8'h5A, 1'b1, 1'b1, 1);
    expect_pad(2);
    expect_pad(3);
    idle(3);
    chk("t3_done", 32'(done), 1);
    chk("t3_count", byte_count, 4);
    chk("t3_drain", exp_q.size(), 0);

    // Overflow: 257 bytes without LAST; START mid-load must be ignored.
    pulse_start();
    for (int i = 0; i < MEM; i++) begin
      start = (i == 100);
      send(8'(i) ^ 8'h5C, 1'b0, 1'b1, AW'(i));
      start = 1'b0;
    end
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_ready_low", 32'(in_ready), 0);
    chk("t4_busy_low", 32'(busy), 0);
    chk("t4_count", byte_count, MEM);
    send(8'hEE, 1'b0, 1'b0, 0);
    idle(3);
    chk("t4_overflow_hold", 32'(overflow), 1);
    chk("t4_count_hold", byte_count, MEM);
    chk("t4_drain", exp_q.size(), 0);

    // Reset after 2 of 4 bytes, then restart from address 0.
    pulse_start();
    chk("t5_overflow_clr", 32'(overflow), 0);
    send(8'hC1, 1'b0, 1'b1, 0);
    send(8'hC2, 1'b0, 1'b1, 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    in_valid = 1'b0;
    chk("t5_rst_we", 32'(we), 0);
    chk("t5_rst_waddr", waddr, 0);
    chk("t5_rst_wd", 32'(wd), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ready", 32'(in_ready), 0);
    chk("t5_rst_count", byte_count, 0);
    chk("t5_rst_done", 32'(done), 0);
    rst_n = 1'b1;
    idle(2);
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), i == 3, 1'b1, AW'(i));
    chk("t5_done", 32'(done), 1);
    chk("t5_count", byte_count, 4);
    idle(2);
    chk("t5_drain", exp_q.size(), 0);

    // LAST exactly on the final memory byte completes without overflow.
    pulse_start();
    for (int i = 0; i < MEM; i++) send(8'hFF - 8'(i), i == MEM - 1, 1'b1, AW'(i));
    chk("t6_done", 32'(done), 1);
    chk("t6_no_overflow", 32'(overflow), 0);
    chk("t6_count", byte_count, MEM);
    idle(2);
    chk("t6_drain", exp_q.size(), 0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    chk("t7_csum_clr", 32'(checksum), 0);
    send(8'h0F, 1'b0, 1'b1, 0);
    send(8'hF0, 1'b0, 1'b1, 1);
    send(8'h01, 1'b0, 1'b1, 2);
    send(8'h00, 1'b1, 1'b1, 3);
    chk("t7_done", 32'(done), 1);
    chk("t7_checksum", 32'(checksum), 32'hFE);
    idle(2);
    chk("t7_drain", exp_q.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the width of the write address and byte count.
REQ-002 Parameter MEM_BYTES, default 256, SHALL be the size in bytes of the target memory; it SHALL be a multiple of 4.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  SHALL be the synchronous, active-low reset.
REQ-005 START  input  1  SHALL be a one-cycle request to begin a new load at byte address 0.
REQ-006 IN_VALID  input  1  SHALL indicate that IN_DATA and IN_LAST hold a valid byte.
REQ-007 IN_DATA  input  8  SHALL carry the byte stream, least-significant byte of each instruction word first.
REQ-008 IN_LAST  input  1  SHALL mark the final byte of the image.
REQ-009 IN_READY  output  1  SHALL indicate that a byte is accepted this cycle when IN_VALID=1.
REQ-010 WE  output  1  SHALL be the byte write-enable to the instruction memory array.
REQ-011 WADDR  output  ADDR_WIDTH  SHALL be the byte address of the write.
REQ-012 WD  output  8  SHALL be the byte written.
REQ-013 BUSY  output  1  SHALL be high in LOAD and PAD; it holds the processor in reset.
REQ-014 DONE  output  1  SHALL be high in state DONE.
REQ-015 OVERFLOW  output  1  SHALL be high in state ERROR.
REQ-016 BYTE_COUNT  output  ADDR_WIDTH  SHALL be the number of bytes written in the current/last load, padding included.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, PAD, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR + START=1 -> LOAD next cycle; pointer, BYTE_COUNT, DONE, OVERFLOW cleared. START in LOAD or PAD ignored.
REQ-019 IN_READY SHALL be 1 only in LOAD; handshake = IN_VALID && IN_READY.
REQ-020 On handshake, the next cycle SHALL show WE=1, WADDR=pointer, WD=IN_DATA (one-cycle registered latency); pointer and BYTE_COUNT increment by 1.
REQ-021 WE SHALL be 0 in every cycle not following a handshake or PAD write.
REQ-022 Handshake with IN_LAST=1 and (pointer+1) mod 4 = 0 -> DONE.
REQ-023 Handshake with IN_LAST=1 and (pointer+1) mod 4 != 0 -> PAD; PAD SHALL write byte 0x00 at successive addresses, one per cycle, until the pointer is word-aligned, then -> DONE.
REQ-024 Handshake at pointer = MEM_BYTES-1 with IN_LAST=0 SHALL write that byte, then -> ERROR; no further bytes accepted.
REQ-025 Handshake at pointer = MEM_BYTES-1 with IN_LAST=1 SHALL -> DONE (aligned, no overflow).
REQ-026 IN_VALID=0 in LOAD SHALL stall indefinitely with no writes.
REQ-027 DONE and ERROR SHALL persist until START or reset.

Reset
REQ-028 RST_N=0 at a rising edge SHALL force IDLE, pointer=0, IN_READY=0, WE=0, WADDR=0, WD=0, BUSY=0, DONE=0, OVERFLOW=0, BYTE_COUNT=0.
REQ-029 Reset mid-LOAD or mid-PAD SHALL abandon the load with no further writes; memory contents already written are left as-is.

Configuration
REQ-030 With macro LOADER_CHECKSUM_EN defined, output CHECKSUM (8 bits) SHALL equal the XOR of all bytes written (pads included), cleared on START and reset, valid in DONE.
REQ-031 Without LOADER_CHECKSUM_EN, the CHECKSUM port and its logic SHALL not exist.

Verification
REQ-032 START, bytes 0x03,0x10,0xA0,0xE3 (LAST on 4th) -> WE at addrs 0..3 with those values, DONE=1, BYTE_COUNT=4, no PAD.
REQ-033 START, 6 bytes 0x11..0x16 (LAST on 6th) -> addrs 4,5 written 0x15,0x16, then 0x00 at 6,7; DONE=1, BYTE_COUNT=8.
REQ-034 MEM_BYTES=256, 257 bytes without LAST -> 256 writes (addr 0..255), OVERFLOW=1, IN_READY=0, 257th byte never written.
REQ-035 IN_VALID toggled 1,0,0,1 during LOAD -> WE only after valid cycles, addresses contiguous 0,1.
REQ-036 RST_N=0 after 2 of 4 bytes -> next cycle all outputs reset values, no further WE; subsequent START restarts at addr 0.
REQ-037 With LOADER_CHECKSUM_EN: bytes 0x0F,0xF0,0x01,0x00 -> CHECKSUM=0xFE in DONE.
